// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared constants, flag bundle and slice sizing for the pipelined CLA adder
package cla_pkg;

    localparam int GROUP_WIDTH = 4;

    typedef struct packed {
        logic overflow;
        logic carry_out;
        logic zero;
        logic negative;
    } cla_flags_t;

    function automatic int slice_width(input int data_width, input int stages);
        return data_width / stages;
    endfunction

endpackage

// File: rtl/cla_slice.sv
// rtl/cla_slice.sv - combinational WIDTH-bit carry-lookahead slice built from 4-bit generate/propagate groups
module cla_slice
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             carry_msb
);

    localparam int GROUPS = WIDTH / GROUP_WIDTH;

    logic [WIDTH-1:0]  g;
    logic [WIDTH-1:0]  p;
    logic [WIDTH:0]    c;
    logic [GROUPS:0]   gc;
    logic [GROUPS-1:0] grp_g;
    logic [GROUPS-1:0] grp_p;

    always_comb begin
        g     = a & b;
        p     = a ^ b;
        grp_g = '0;
        grp_p = '1;
        gc    = '0;
        c     = '0;
        for (int j = 0; j < GROUPS; j++) begin
            for (int t = 0; t < GROUP_WIDTH; t++) begin
                grp_g[j] = g[j*GROUP_WIDTH+t] | (p[j*GROUP_WIDTH+t] & grp_g[j]);
                grp_p[j] = grp_p[j] & p[j*GROUP_WIDTH+t];
            end
        end
        // Group carries come from lookahead; bit carries only ripple inside a group.
        gc[0] = cin;
        for (int j = 0; j < GROUPS; j++) begin
            gc[j+1] = grp_g[j] | (grp_p[j] & gc[j]);
        end
        for (int j = 0; j < GROUPS; j++) begin
            c[j*GROUP_WIDTH] = gc[j];
            for (int t = 0; t < GROUP_WIDTH - 1; t++) begin
                c[j*GROUP_WIDTH+t+1] = g[j*GROUP_WIDTH+t] | (p[j*GROUP_WIDTH+t] & c[j*GROUP_WIDTH+t]);
            end
        end
        c[WIDTH] = gc[GROUPS];
    end

    assign sum       = p ^ c[WIDTH-1:0];
    assign cout      = c[WIDTH];
    assign carry_msb = c[WIDTH-1];

endmodule

// File: rtl/pipelined_cla_adder.sv
// rtl/pipelined_cla_adder.sv - STAGES-deep pipelined add/subtract with flags, tag and backpressure
// Optional signed clamp on overflow when CLA_SATURATE_EN is defined.
module pipelined_cla_adder
    import cla_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int STAGES     = 4,
    parameter int TAG_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  sub,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  overflow,
    output logic                  carry_out,
    output logic                  zero,
    output logic                  negative,
    output logic [TAG_WIDTH-1:0]  out_tag
);

    localparam int SW = slice_width(DATA_WIDTH, STAGES);

    // Operand registers shift right by one slice per stage, so the next slice is always at the LSBs;
    // sum registers shift right too, filling from the top, so the last stage holds the result in order.
    logic                  valid_q [STAGES];
    logic                  valid_d [STAGES];
    logic [TAG_WIDTH-1:0]  tag_q   [STAGES];
    logic [TAG_WIDTH-1:0]  tag_d   [STAGES];
    logic [DATA_WIDTH-1:0] op_a_q  [STAGES];
    logic [DATA_WIDTH-1:0] op_a_d  [STAGES];
    logic [DATA_WIDTH-1:0] op_b_q  [STAGES];
    logic [DATA_WIDTH-1:0] op_b_d  [STAGES];
    logic [DATA_WIDTH-1:0] sum_q   [STAGES];
    logic [DATA_WIDTH-1:0] sum_d   [STAGES];
    logic                  carry_q [STAGES];
    logic                  carry_d [STAGES];
    cla_flags_t            flags_q;
    cla_flags_t            flags_d;

    logic                  stg_valid [STAGES];
    logic [TAG_WIDTH-1:0]  stg_tag   [STAGES];
    logic [DATA_WIDTH-1:0] stg_a     [STAGES];
    logic [DATA_WIDTH-1:0] stg_b     [STAGES];
    logic [DATA_WIDTH-1:0] stg_sum   [STAGES];
    logic                  stg_cin   [STAGES];
    logic [SW-1:0]         sl_sum    [STAGES];
    logic                  sl_cout   [STAGES];
    logic                  sl_cmsb   [STAGES];

    logic                  advance;
    logic                  raw_ovf;
    logic [DATA_WIDTH-1:0] final_res;

`ifdef CLA_SATURATE_EN
    localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    logic sign_q   [STAGES];
    logic sign_d   [STAGES];
    logic stg_sign [STAGES];
`endif

    genvar k;
    for (k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign stg_valid[k] = in_valid;
            assign stg_tag[k]   = in_tag;
            assign stg_a[k]     = a;
            assign stg_b[k]     = sub ? ~b : b;
            assign stg_sum[k]   = '0;
            assign stg_cin[k]   = sub;
`ifdef CLA_SATURATE_EN
            assign stg_sign[k]  = a[DATA_WIDTH-1];
`endif
        end else begin : g_next
            assign stg_valid[k] = valid_q[k-1];
            assign stg_tag[k]   = tag_q[k-1];
            assign stg_a[k]     = op_a_q[k-1];
            assign stg_b[k]     = op_b_q[k-1];
            assign stg_sum[k]   = sum_q[k-1];
            assign stg_cin[k]   = carry_q[k-1];
`ifdef CLA_SATURATE_EN
            assign stg_sign[k]  = sign_q[k-1];
`endif
        end

        cla_slice #(.WIDTH(SW)) u_slice (
            .a         (stg_a[k][SW-1:0]),
            .b         (stg_b[k][SW-1:0]),
            .cin       (stg_cin[k]),
            .sum       (sl_sum[k]),
            .cout      (sl_cout[k]),
            .carry_msb (sl_cmsb[k])
        );
    end

    always_comb begin
        advance   = !valid_q[STAGES-1] || out_ready;
        raw_ovf   = sl_cmsb[STAGES-1] ^ sl_cout[STAGES-1];
        final_res = (stg_sum[STAGES-1] >> SW) | (DATA_WIDTH'(sl_sum[STAGES-1]) << (DATA_WIDTH - SW));
`ifdef CLA_SATURATE_EN
        if (raw_ovf) begin
            final_res = stg_sign[STAGES-1] ? SAT_MIN : SAT_MAX;
        end
`endif
        flags_d = flags_q;
        for (int i = 0; i < STAGES; i++) begin
            valid_d[i] = valid_q[i];
            tag_d[i]   = tag_q[i];
            op_a_d[i]  = op_a_q[i];
            op_b_d[i]  = op_b_q[i];
            sum_d[i]   = sum_q[i];
            carry_d[i] = carry_q[i];
`ifdef CLA_SATURATE_EN
            sign_d[i]  = sign_q[i];
`endif
        end
        if (advance) begin
            for (int i = 0; i < STAGES; i++) begin
                valid_d[i] = stg_valid[i];
                tag_d[i]   = stg_tag[i];
                op_a_d[i]  = stg_a[i] >> SW;
                op_b_d[i]  = stg_b[i] >> SW;
                sum_d[i]   = (stg_sum[i] >> SW) | (DATA_WIDTH'(sl_sum[i]) << (DATA_WIDTH - SW));
                carry_d[i] = sl_cout[i];
`ifdef CLA_SATURATE_EN
                sign_d[i]  = stg_sign[i];
`endif
            end
            sum_d[STAGES-1]   = final_res;
            flags_d.overflow  = raw_ovf;
            flags_d.carry_out = sl_cout[STAGES-1];
            flags_d.zero      = (final_res == '0);
            flags_d.negative  = final_res[DATA_WIDTH-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                op_a_q[i]  <= '0;
                op_b_q[i]  <= '0;
                sum_q[i]   <= '0;
                carry_q[i] <= 1'b0;
`ifdef CLA_SATURATE_EN
                sign_q[i]  <= 1'b0;
`endif
            end
        end else begin
            flags_q <= flags_d;
            for (int i = 0; i < STAGES; i++) begin
                valid_q[i] <= valid_d[i];
                tag_q[i]   <= tag_d[i];
                op_a_q[i]  <= op_a_d[i];
                op_b_q[i]  <= op_b_d[i];
                sum_q[i]   <= sum_d[i];
                carry_q[i] <= carry_d[i];
`ifdef CLA_SATURATE_EN
                sign_q[i]  <= sign_d[i];
`endif
            end
        end
    end

    assign in_ready  = advance;
    assign out_valid = valid_q[STAGES-1];
    assign out_tag   = tag_q[STAGES-1];
    assign result    = sum_q[STAGES-1];
    assign overflow  = flags_q.overflow;
    assign carry_out = flags_q.carry_out;
    assign zero      = flags_q.zero;
    assign negative  = flags_q.negative;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// tb/tb_pipelined_cla_adder.sv - randomized self-checking bench for pipelined_cla_adder (64-bit, 4 stages)
module tb_pipelined_cla_adder;

    localparam int DW = 64;
    localparam int ST = 4;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          sub;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] result;
    logic          overflow;
    logic          carry_out;
    logic          zero;
    logic          negative;
    logic [TW-1:0] out_tag;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [DW-1:0] res;
        logic [3:0]    flags;
        logic [TW-1:0] tag;
    } exp_t;

    exp_t exp_q[$];

    pipelined_cla_adder #(.DATA_WIDTH(DW), .STAGES(ST), .TAG_WIDTH(TW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .overflow(overflow), .carry_out(carry_out), .zero(zero), .negative(negative),
        .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    // Reference: wide-integer arithmetic, flags ordered {overflow, carry_out, zero, negative}.
    function automatic exp_t model(input logic [DW-1:0] x, input logic [DW-1:0] y,
                                   input logic s, input logic [TW-1:0] t);
        exp_t          e;
        logic [DW:0]   full;
        logic [DW-1:0] yy;
        logic [DW-1:0] r;
        logic          ovf;
        yy   = s ? ~y : y;
        full = {1'b0, x} + {1'b0, yy} + {{DW{1'b0}}, s};
        r    = full[DW-1:0];
        ovf  = (x[DW-1] == yy[DW-1]) && (r[DW-1] != x[DW-1]);
`ifdef CLA_SATURATE_EN
        if (ovf) r = x[DW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
`endif
        e.res   = r;
        e.flags = {ovf, full[DW], (r == '0), r[DW-1]};
        e.tag   = t;
        return e;
    endfunction

    function automatic logic [DW-1:0] rand_operand();
        logic [DW-1:0] v;
        case ($urandom_range(0, 5))
            0:       v = '1;
            1:       v = {1'b1, {(DW-1){1'b0}}};
            2:       v = {1'b0, {(DW-1){1'b1}}};
            3:       v = DW'($urandom_range(0, 3));
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    task automatic issue_one(input logic [DW-1:0] x, input logic [DW-1:0] y, input logic s,
                             input logic [TW-1:0] t, output logic [DW-1:0] r,
                             output logic [3:0] f, output logic [TW-1:0] tg, output int lat);
        @(negedge clk);
        a = x; b = y; sub = s; in_tag = t; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        r  = result;
        f  = {overflow, carry_out, zero, negative};
        tg = out_tag;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; sub = 1'b0; in_tag = '0;
        repeat (2) @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        total++; if (result !== '0) begin bad++; $display("FAIL reset_result: got %h want 0", result); end
        total++; if ({overflow, carry_out, zero, negative} !== 4'b0) begin bad++;
            $display("FAIL reset_flags: got %b want 0000", {overflow, carry_out, zero, negative}); end
        total++; if (out_tag !== '0) begin bad++; $display("FAIL reset_tag: got %h want 0", out_tag); end
        reset = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_directed();
        logic [DW-1:0] xa [5];
        logic [DW-1:0] xb [5];
        logic          xs [5];
        logic [DW-1:0] xr [5];
        logic [3:0]    xf [5];
        logic [DW-1:0] r;
        logic [3:0]    f;
        logic [TW-1:0] tg;
        int            lat;
        xa[0] = 64'd5;                  xb[0] = 64'd6;                  xs[0] = 1'b0;
        xr[0] = 64'd11;                 xf[0] = 4'b0000;
        xa[1] = 64'd5;                  xb[1] = 64'd6;                  xs[1] = 1'b1;
        xr[1] = 64'hFFFF_FFFF_FFFF_FFFF; xf[1] = 4'b0001;
        xa[2] = 64'h8000_0000_0000_0000; xb[2] = 64'd1;                  xs[2] = 1'b1;
        xa[3] = 64'hFFFF_FFFF_FFFF_FFFF; xb[3] = 64'd1;                  xs[3] = 1'b0;
        xr[3] = 64'd0;                  xf[3] = 4'b0110;
        xa[4] = 64'h4000_0000_0000_0000; xb[4] = 64'h4000_0000_0000_0000; xs[4] = 1'b0;
`ifdef CLA_SATURATE_EN
        xr[2] = 64'h8000_0000_0000_0000; xf[2] = 4'b1101;
        xr[4] = 64'h7FFF_FFFF_FFFF_FFFF; xf[4] = 4'b1000;
`else
        xr[2] = 64'h7FFF_FFFF_FFFF_FFFF; xf[2] = 4'b1100;
        xr[4] = 64'h8000_0000_0000_0000; xf[4] = 4'b1001;
`endif
        for (int i = 0; i < 5; i++) begin
            issue_one(xa[i], xb[i], xs[i], TW'(i + 9), r, f, tg, lat);
            total++; if (lat !== ST) begin bad++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, ST); end
            total++; if (r !== xr[i]) begin bad++; $display("FAIL dir%0d_result: got %h want %h", i, r, xr[i]); end
            total++; if (f !== xf[i]) begin bad++; $display("FAIL dir%0d_flags: got %b want %b", i, f, xf[i]); end
            total++; if (tg !== TW'(i + 9)) begin bad++; $display("FAIL dir%0d_tag: got %h want %h", i, tg, TW'(i + 9)); end
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] x, y, r;
        logic          s;
        logic [3:0]    f;
        logic [TW-1:0] tg, t;
        int            lat;
        exp_t          e;
        for (int i = 0; i < 12; i++) begin
            x = rand_operand(); y = rand_operand(); s = 1'($urandom_range(0, 1)); t = TW'($urandom);
            e = model(x, y, s, t);
            issue_one(x, y, s, t, r, f, tg, lat);
            total++; if (lat !== ST) begin bad++; $display("FAIL rnd%0d_latency: got %0d want %0d", i, lat, ST); end
            total++; if ({r, f, tg} !== {e.res, e.flags, e.tag}) begin bad++;
                $display("FAIL rnd%0d_out: got %h/%b/%h want %h/%b/%h", i, r, f, tg, e.res, e.flags, e.tag); end
        end
    endtask

    task automatic test_back_to_back();
        int                       sent = 0;
        int                       got = 0;
        logic                     need_new = 1'b1;
        logic                     held_valid = 1'b0;
        logic [DW+4+TW-1:0]       held = '0;
        exp_t                     e;
        exp_q.delete();
        in_valid = 1'b0;
        for (int c = 0; c < 60 && got < 8; c++) begin
            @(negedge clk);
            out_ready = !(c >= 5 && c <= 7);
            if (need_new) begin
                need_new = 1'b0;
                if (sent < 8) begin
                    a = rand_operand(); b = rand_operand(); sub = 1'($urandom_range(0, 1));
                    in_tag = TW'(sent); in_valid = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
            end
            #1;
            if (held_valid) begin
                total++; if ({result, overflow, carry_out, zero, negative, out_tag} !== held) begin bad++;
                    $display("FAIL b2b_stall_stable c=%0d: got %h want %h", c,
                             {result, overflow, carry_out, zero, negative, out_tag}, held); end
            end
            total++; if (in_ready !== (!out_valid || out_ready)) begin bad++;
                $display("FAIL b2b_in_ready c=%0d: got %b want %b", c, in_ready, !out_valid || out_ready); end
            if (out_valid && out_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL b2b_unexpected c=%0d: got tag %h want none", c, out_tag);
                end else begin
                    e = exp_q.pop_front();
                    if ({result, overflow, carry_out, zero, negative, out_tag} !== {e.res, e.flags, e.tag}) begin
                        bad++; $display("FAIL b2b_out c=%0d: got %h/%b/%h want %h/%b/%h", c, result,
                                        {overflow, carry_out, zero, negative}, out_tag, e.res, e.flags, e.tag);
                    end
                end
                got++;
                held_valid = 1'b0;
            end else if (out_valid) begin
                held_valid = 1'b1;
                held = {result, overflow, carry_out, zero, negative, out_tag};
            end else begin
                held_valid = 1'b0;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, sub, in_tag));
                sent++;
                need_new = 1'b1;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        total++; if (got !== 8) begin bad++; $display("FAIL b2b_count: got %0d want 8", got); end
        total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL b2b_leftover: got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_reset_flush();
        logic [DW-1:0] r;
        logic [3:0]    f;
        logic [TW-1:0] tg;
        int            lat;
        int            wait_cyc;
        int            seen;
        exp_t          e;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a = {$urandom, $urandom}; b = {$urandom, $urandom}; sub = 1'b0; in_tag = TW'(i + 4); in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        wait_cyc = 0;
        while (!out_valid && wait_cyc < 20) begin
            @(negedge clk);
            wait_cyc++;
        end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL flush_pre_valid: got %b want 1", out_valid); end
        reset = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_out_valid: got %b want 0", out_valid); end
        total++; if ({result, out_tag} !== '0) begin bad++; $display("FAIL flush_outputs: got %h want 0", {result, out_tag}); end
        @(negedge clk);
        reset = 1'b0; out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL flush_ghost: got %0d want 0", seen); end
        e = model(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b1, 4'hE);
        issue_one(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b1, 4'hE, r, f, tg, lat);
        total++; if (lat !== ST) begin bad++; $display("FAIL flush_next_latency: got %0d want %0d", lat, ST); end
        total++; if ({r, f, tg} !== {e.res, e.flags, e.tag}) begin bad++;
            $display("FAIL flush_next_out: got %h/%b/%h want %h/%b/%h", r, f, tg, e.res, e.flags, e.tag); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_flush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule
